// File: rtl/hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// hazard_controller_pkg
//   Shared types for the EX-stage hazard controller.
//   hzd_state_e : sequencer state (RUN / MEM_WAIT / HALT)
//   hzd_ctrl_t  : pipeline control bundle, four register enables and three
//                 bubble-insert flushes, in the order the pipeline consumes them
//   CTRL_*      : canned control bundles for the common pipeline actions
// ---------------------------------------------------------------------------
package hazard_controller_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } hzd_state_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_flush;
   } hzd_ctrl_t;

   // Free-running pipeline, nothing squashed.
   localparam hzd_ctrl_t CTRL_RUN = '{
      pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
      if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
   };

   // Whole front end frozen while the LSU port is busy; MEM/WB gets a bubble
   // so the stalled access is not retired twice.
   localparam hzd_ctrl_t CTRL_MEM_FREEZE = '{
      pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
      if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b1
   };

   // Branch resolved wrong in EX: keep fetching from the corrected PC and
   // squash the two younger instructions.
   localparam hzd_ctrl_t CTRL_MISPRED = '{
      pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
      if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_flush: 1'b0
   };

   // Load-use: hold PC and IF/ID, let the load advance, put a bubble in EX.
   // id_ex_en stays high; the flush wins at the register anyway.
   localparam hzd_ctrl_t CTRL_LOAD_USE = '{
      pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
      if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_flush: 1'b0
   };

   // Fatal timeout: everything frozen, nothing injected.
   localparam hzd_ctrl_t CTRL_HALT = '{
      pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
      if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_flush: 1'b0
   };

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter for hazard performance statistics.
//   Ports:
//     clk   : clock
//     clr   : synchronous clear (dominates inc)
//     inc   : count one event this cycle
//     count : current value, sticks at all-ones
// ---------------------------------------------------------------------------
module sat_counter
   import hazard_controller_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic at_max;

   assign at_max = &count;

   always_ff @(posedge clk) begin
      if (clr) begin
         count <= '0;
      end else if (inc && !at_max) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// ---------------------------------------------------------------------------
// hazard_controller
//   Pipeline sequencer for the EX-stage operand/forwarding datapath. Stalls on
//   load-use hazards forwarding cannot cover, flushes on branch mispredict,
//   freezes the pipeline while the LSU port is busy and halts if the port
//   never answers. Control outputs are combinational from state and inputs.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   RUN      | normal flow; stalls/flushes decided per cycle
//   MEM_WAIT | LSU busy, pipeline frozen; timeout timer running
//   HALT     | LSU timed out; pipeline frozen until reset
//
//   Ports:
//     i_clk, i_rst              : clock, synchronous active-high reset
//     i_id_*                    : source registers/usage of the ID instruction
//     i_ex_*                    : destination/load/mispredict of EX instruction
//     i_mem_req, i_mem_ready    : LSU handshake from MEM
//     o_pc_en .. o_ex_mem_en    : pipeline register enables
//     o_*_flush                 : bubble inserts (dominate the enables)
//     o_halted                  : sticky timeout flag
//     o_stall_cycles            : saturating count of stalled cycles
//     o_flush_count             : saturating count of mispredict flushes
// ---------------------------------------------------------------------------
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_id_rs1_addr,
   input  logic [4:0]       i_id_rs2_addr,
   input  logic             i_id_use_rs1,
   input  logic             i_id_use_rs2,
   input  logic             i_id_valid,
   input  logic [4:0]       i_ex_rd_addr,
   input  logic             i_ex_load_en,
   input  logic             i_ex_valid,
   input  logic             i_ex_mispredict,
   input  logic             i_mem_req,
   input  logic             i_mem_ready,
   output logic             o_pc_en,
   output logic             o_if_id_en,
   output logic             o_id_ex_en,
   output logic             o_ex_mem_en,
   output logic             o_if_id_flush,
   output logic             o_id_ex_flush,
   output logic             o_mem_wb_flush,
   output logic             o_halted,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count
);

   // The timeout timer counts down the MEM_WAIT cycles still allowed. The
   // busy cycle seen in RUN is the first of MEM_TIMEOUT, and the MEM_WAIT
   // cycle that finds the timer at zero is the last, so the load value is
   // MEM_TIMEOUT-2.
   localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT - 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(MEM_TIMEOUT - 2);

   hzd_state_e        state;
   logic [WAIT_W-1:0] wait_left;
   logic              halted;

   logic      mem_busy;
   logic      mispred;
   logic      load_use;
   logic      rs1_hit;
   logic      rs2_hit;
   hzd_ctrl_t ctrl;
   logic      stall_inc;
   logic      flush_inc;

   assign mem_busy = i_mem_req && !i_mem_ready;
   assign mispred  = i_ex_valid && i_ex_mispredict;

   // x0 never carries a real result, so a load to x0 cannot create a hazard.
   assign rs1_hit  = i_id_use_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
   assign rs2_hit  = i_id_use_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
   assign load_use = i_ex_valid && i_ex_load_en && (i_ex_rd_addr != 5'd0)
                     && i_id_valid && (rs1_hit || rs2_hit);

   // RUN and MEM_WAIT share one decision: a wait that releases this cycle
   // is handled exactly like RUN, so no dead cycle follows the release and
   // any hazard held during the wait is acted on now.
   always_comb begin
      ctrl      = CTRL_RUN;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      if (!i_rst) begin
         case (state)
            RUN, MEM_WAIT: begin
               if (mem_busy) begin
                  ctrl      = CTRL_MEM_FREEZE;
                  stall_inc = 1'b1;
               end else if (mispred) begin
                  // A coincident load-use is squashed along with ID.
                  ctrl      = CTRL_MISPRED;
                  flush_inc = 1'b1;
               end else if (load_use) begin
                  ctrl      = CTRL_LOAD_USE;
                  stall_inc = 1'b1;
               end
            end
            HALT: begin
               ctrl = CTRL_HALT;
            end
            default: begin
               ctrl = CTRL_RUN;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= RUN;
         wait_left <= '0;
         halted    <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_busy) begin
                  state     <= MEM_WAIT;
                  wait_left <= WAIT_LOAD;
               end
            end
            MEM_WAIT: begin
               if (mem_busy) begin
                  if (wait_left == '0) begin
                     state  <= HALT;
                     halted <= 1'b1;
                  end else begin
                     wait_left <= wait_left - WAIT_W'(1);
                  end
               end else begin
                  state     <= RUN;
                  wait_left <= '0;
               end
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state     <= RUN;
               wait_left <= '0;
            end
         endcase
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_stall_cnt (
      .clk   (i_clk),
      .clr   (i_rst),
      .inc   (stall_inc),
      .count (o_stall_cycles)
   );

   sat_counter #(
      .W (CNT_W)
   ) u_flush_cnt (
      .clk   (i_clk),
      .clr   (i_rst),
      .inc   (flush_inc),
      .count (o_flush_count)
   );

   assign o_pc_en        = ctrl.pc_en;
   assign o_if_id_en     = ctrl.if_id_en;
   assign o_id_ex_en     = ctrl.id_ex_en;
   assign o_ex_mem_en    = ctrl.ex_mem_en;
   assign o_if_id_flush  = ctrl.if_id_flush;
   assign o_id_ex_flush  = ctrl.id_ex_flush;
   assign o_mem_wb_flush = ctrl.mem_wb_flush;
   assign o_halted       = halted;

endmodule

// File: tb/tb_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_controller
//   Directed and random stimulus for hazard_controller with a small
//   behavioural model (consecutive-busy run length, sticky halt, clamped
//   integer counters). Built with MEM_TIMEOUT=4 and CNT_W=4 so timeout and
//   saturation are reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_controller;

   localparam int T_OUT = 4;
   localparam int CW    = 4;
   localparam int CMAX  = (1 << CW) - 1;

   logic          clk;
   logic          rst;
   logic [4:0]    rs1, rs2, rd;
   logic          use1, use2, idv, ld, exv, mis, req, rdy;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic          if_id_flush, id_ex_flush, mem_wb_flush;
   logic          halted;
   logic [CW-1:0] stall_cycles, flush_count;

   int n_cmp;
   int n_bad;

   // Model state
   int m_busy_run;
   bit m_halted;
   int m_stall;
   int m_flush;

   hazard_controller #(
      .MEM_TIMEOUT (T_OUT),
      .CNT_W       (CW)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_id_rs1_addr   (rs1),
      .i_id_rs2_addr   (rs2),
      .i_id_use_rs1    (use1),
      .i_id_use_rs2    (use2),
      .i_id_valid      (idv),
      .i_ex_rd_addr    (rd),
      .i_ex_load_en    (ld),
      .i_ex_valid      (exv),
      .i_ex_mispredict (mis),
      .i_mem_req       (req),
      .i_mem_ready     (rdy),
      .o_pc_en         (pc_en),
      .o_if_id_en      (if_id_en),
      .o_id_ex_en      (id_ex_en),
      .o_ex_mem_en     (ex_mem_en),
      .o_if_id_flush   (if_id_flush),
      .o_id_ex_flush   (id_ex_flush),
      .o_mem_wb_flush  (mem_wb_flush),
      .o_halted        (halted),
      .o_stall_cycles  (stall_cycles),
      .o_flush_count   (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] dut_ctrl();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic bit m_mem_busy();
      return req && !rdy;
   endfunction

   function automatic bit m_mispred();
      return exv && mis;
   endfunction

   function automatic bit m_load_use();
      bit reads_rd;
      reads_rd = (use1 && rs1 == rd) || (use2 && rs2 == rd);
      return exv && ld && (rd != 5'd0) && idv && reads_rd;
   endfunction

   // Control bundle order: pc, if_id, id_ex, ex_mem enables; if_id, id_ex, mem_wb flushes
   function automatic logic [6:0] m_ctrl();
      if (rst)               return 7'b1111_000;
      if (m_halted)          return 7'b0000_000;
      if (m_mem_busy())      return 7'b0000_001;
      if (m_mispred())       return 7'b1111_110;
      if (m_load_use())      return 7'b0011_010;
      return 7'b1111_000;
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_busy_run = 0;
         m_halted   = 1'b0;
         m_stall    = 0;
         m_flush    = 0;
      end else if (!m_halted) begin
         if (m_mem_busy()) begin
            m_busy_run++;
            m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (m_busy_run == T_OUT) m_halted = 1'b1;
         end else begin
            m_busy_run = 0;
            if (m_mispred())       m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            else if (m_load_use()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
         end
      end
   endtask

   // Sample at the falling edge, then advance the model with the clock.
   task automatic half();
      @(negedge clk);
      chk("ctrl", 32'(dut_ctrl()), 32'(m_ctrl()));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      chk("flush_count", 32'(flush_count), 32'(m_flush));
   endtask

   task automatic edge_adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic step();
      half();
      edge_adv();
   endtask

   task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                         input logic iv, input logic [4:0] d, input logic l, input logic ev,
                         input logic mp, input logic rq, input logic ry);
      rs1 = a1; rs2 = a2; use1 = u1; use2 = u2; idv = iv;
      rd = d; ld = l; exv = ev; mis = mp; req = rq; rdy = ry;
   endtask

   task automatic idle();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic busy();
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      m_busy_run = 0;
      m_halted   = 1'b0;
      m_stall    = 0;
      m_flush    = 0;
      rst        = 1'b1;

      // Reset holds RUN-idle outputs even with hazards on the inputs.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      edge_adv();
      half();
      chk("rst_ctrl", 32'(dut_ctrl()), 32'h78);
      edge_adv();
      rst = 1'b0;
      idle();
      half();
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_flush", 32'(flush_count), 32'd0);
      edge_adv();

      // lw x5 in EX, add reading x5 in ID: one bubble, then free flow.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      half();
      chk("lu_ctrl", 32'(dut_ctrl()), 32'h1a);
      edge_adv();
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      half();
      chk("lu_after_ctrl", 32'(dut_ctrl()), 32'h78);
      chk("lu_stall", 32'(stall_cycles), 32'd1);
      edge_adv();

      // Load to x0, and a matching rs2 that the instruction does not read.
      set_in(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      half();
      chk("x0_ctrl", 32'(dut_ctrl()), 32'h78);
      edge_adv();
      set_in(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      half();
      chk("rs2_unused_ctrl", 32'(dut_ctrl()), 32'h78);
      edge_adv();
      // rs2 match that is read does stall.
      set_in(5'd3, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      half();
      chk("rs2_used_ctrl", 32'(dut_ctrl()), 32'h1a);
      edge_adv();

      // Mispredict with a coincident load-use: flush only.
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      half();
      chk("mp_ctrl", 32'(dut_ctrl()), 32'h7e);
      edge_adv();
      idle();
      half();
      chk("mp_flush", 32'(flush_count), 32'd1);
      chk("mp_stall", 32'(stall_cycles), 32'd2);
      edge_adv();

      // Three busy cycles, release with a mispredict in the same cycle.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         busy();
         half();
         chk("mw_ctrl", 32'(dut_ctrl()), 32'h01);
         edge_adv();
      end
      set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      half();
      chk("mw_release_ctrl", 32'(dut_ctrl()), 32'h7e);
      edge_adv();
      idle();
      half();
      chk("mw_stall", 32'(stall_cycles), 32'd3);
      chk("mw_flush", 32'(flush_count), 32'd1);
      chk("mw_halted", 32'(halted), 32'd0);
      edge_adv();

      // Timeout: four busy cycles then HALT, exit only by reset.
      do_reset();
      for (int i = 0; i < T_OUT; i++) begin
         busy();
         step();
      end
      busy();
      half();
      chk("halt_ctrl", 32'(dut_ctrl()), 32'h00);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_stall", 32'(stall_cycles), 32'd4);
      edge_adv();
      set_in(5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      half();
      chk("halt_hold_ctrl", 32'(dut_ctrl()), 32'h00);
      edge_adv();
      step();
      do_reset();
      idle();
      half();
      chk("halt_exit_halted", 32'(halted), 32'd0);
      chk("halt_exit_stall", 32'(stall_cycles), 32'd0);
      chk("halt_exit_ctrl", 32'(dut_ctrl()), 32'h78);
      edge_adv();

      // Reset in the middle of a wait restarts the timeout run.
      busy(); step();
      busy(); step();
      rst = 1'b1; busy(); step(); rst = 1'b0;
      for (int i = 0; i < T_OUT - 1; i++) begin
         busy(); step();
      end
      idle();
      half();
      chk("midwait_halted", 32'(halted), 32'd0);
      edge_adv();

      // Saturation of both counters.
      do_reset();
      for (int i = 0; i < 20; i++) begin
         set_in(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
         step();
      end
      for (int i = 0; i < 20; i++) begin
         set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
         step();
      end
      idle();
      half();
      chk("sat_stall", 32'(stall_cycles), 32'd15);
      chk("sat_flush", 32'(flush_count), 32'd15);
      edge_adv();

      // Random mix with small register numbers so hazards are frequent.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)));
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencer for the EX-stage operand/forwarding datapath.
- Detects load-use hazards that forwarding cannot cover and handles branch mispredict flushes.
- Holds the pipeline while the LSU memory port is busy.
- Drives enable/flush controls for PC, IF/ID, ID/EX and EX/MEM registers, and keeps hazard performance counters.
- Sits beside the forwarding unit; consumes decode info from ID, EX and MEM.

Parameters:
- MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before fatal halt (≥2)
- CNT_W, 32, width of saturating performance counters

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_id_rs1_addr  in  5  rs1 of instruction in ID
- i_id_rs2_addr  in  5  rs2 of instruction in ID
- i_id_use_rs1  in  1  ID instruction reads rs1
- i_id_use_rs2  in  1  ID instruction reads rs2
- i_id_valid  in  1  ID slot holds a real instruction
- i_ex_rd_addr  in  5  rd of instruction in EX
- i_ex_load_en  in  1  EX instruction is a load
- i_ex_valid  in  1  EX slot valid
- i_ex_mispredict  in  1  EX branch outcome ≠ prediction
- i_mem_req  in  1  MEM stage issuing a load/store
- i_mem_ready  in  1  data memory accepts/completes this cycle
- o_pc_en  out  1  PC register update enable
- o_if_id_en  out  1  IF/ID register enable
- o_id_ex_en  out  1  ID/EX register enable
- o_ex_mem_en  out  1  EX/MEM register enable
- o_if_id_flush  out  1  load bubble (valid=0) into IF/ID
- o_id_ex_flush  out  1  load bubble into ID/EX
- o_mem_wb_flush  out  1  load bubble into MEM/WB
- o_halted  out  1  sticky fatal-timeout flag
- o_stall_cycles  out  CNT_W  cycles lost to stalls (saturating)
- o_flush_count  out  CNT_W  mispredict flushes (saturating)

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Outputs are Mealy: combinational from state and inputs. State, wait counter and perf counters are registered.
- Reset (sync, i_rst=1 at posedge):
  - state=RUN, wait_cnt=0, both counters=0, o_halted=0.
  - While i_rst=1, outputs take RUN-idle values: all enables 1, all flushes 0.
  - Reset mid-MEM_WAIT or in HALT returns to RUN on the next edge.
- Terms:
  - mem_busy = i_mem_req & ~i_mem_ready.
  - load_use = i_ex_valid & i_ex_load_en & i_ex_rd_addr≠0 & i_id_valid & ((i_id_use_rs1 & rs1==rd) | (i_id_use_rs2 & rs2==rd)).
  - mispred = i_ex_valid & i_ex_mispredict.
- RUN, priority mem_busy > mispred > load_use:
  - mem_busy: all four enables 0, o_mem_wb_flush=1; wait_cnt←1; next MEM_WAIT; stall_cycles+1.
  - mispred: all enables 1, o_if_id_flush=1, o_id_ex_flush=1; flush_count+1. A coincident load_use is ignored because the ID instruction is squashed.
  - load_use: o_pc_en=0, o_if_id_en=0, o_id_ex_flush=1, o_ex_mem_en=1; stall_cycles+1. Exactly one bubble per hazard; the next cycle sees a bubble in EX.
  - none: all enables 1, no flush.
- MEM_WAIT:
  - mem_busy still true: same outputs as RUN mem_busy case; wait_cnt+1; stall_cycles+1.
    - If wait_cnt==MEM_TIMEOUT-1 at that edge: next HALT, o_halted←1.
  - mem_busy false: evaluate exactly as RUN in the same cycle (no extra dead cycle); next RUN; wait_cnt←0.
  - Mispredict or load-use visible during the wait is held in place by the frozen registers and acted on at release.
- HALT: all enables 0, all flushes 0, o_halted=1. Exit only by reset.
- Counters saturate at all-ones and never wrap.
- Flush signals dominate enables at the register: flush loads a bubble even when the enable is 1.

Decomposition:
- Shared package: typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} hzd_state_e, and a packed hzd_ctrl_t struct bundling the 4 enables and 3 flushes, exported as pipeline control.
- One sub-module: sat_counter (parameter W, inputs inc and clr), instantiated twice.
- Load-use compare stays inline.

Test Plan:
- Load-use: EX lw x5 (rd=5, load_en=1); ID add uses rs1=5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; next cycle all enables 1; stall_cycles=1.
- rd=x0 load with ID rs1=0, and a load-use where use_rs2=0 but rs2 matches → no stall.
- Mispredict with simultaneous load_use → if_id_flush=id_ex_flush=1, pc_en=1, flush_count=1, stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then 1 → 3 cycles of all enables 0 and mem_wb_flush=1; release cycle has normal outputs; state RUN; stall_cycles=3.
- MEM_TIMEOUT=4, mem_ready held 0 → HALT after 4 busy cycles, o_halted=1, enables 0; i_rst pulse → RUN, counters 0.
- Force stall_cycles near saturation (CNT_W=4, 20 stalls) → holds at 15.
